// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with one shared period counter.
// Each channel has a shadow duty (written by load or by edge-detected,
// saturating inc/dec requests) and an active duty that is refreshed from
// the shadow only at a period boundary, so a duty change never produces a
// partial period. Edge-aligned and center-aligned counting are supported.
module pwm_multi_ch #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 2 ** (WIDTH - 1),
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                center,
    input  logic [CHANNELS-1:0] duty_inc,
    input  logic [CHANNELS-1:0] duty_dec,
    input  logic                load,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic [WIDTH-1:0]    duty_in,
    output logic [CHANNELS-1:0] PWM_out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX};
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(DUTY_INIT);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    // Shared counter state
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             dir_up_reg, dir_up_next;
    logic             mode_reg, mode_next;      // 1 = center-aligned
    logic             boundary;

    // Request edge detection
    logic [CHANNELS-1:0] inc_prev_reg, dec_prev_reg;
    logic [CHANNELS-1:0] inc_edge, dec_edge;

    logic period_start_reg;

    // A boundary is the cnt==0 cycle on the way up; it starts every period.
    assign boundary = (cnt_reg == '0) && dir_up_reg;
    assign inc_edge = duty_inc & ~inc_prev_reg;
    assign dec_edge = duty_dec & ~dec_prev_reg;

    // Next counter value, direction and latched mode.
    // At a boundary cnt is 0 and both modes step to 1, so the mode used for
    // stepping can be the latched one even on the cycle the mode changes.
    always_comb begin
        cnt_next    = cnt_reg;
        dir_up_next = dir_up_reg;
        mode_next   = mode_reg;
        if (!en) begin
            cnt_next    = '0;
            dir_up_next = 1'b1;
            mode_next   = center;
        end else begin
            if (boundary) begin
                mode_next = center;
            end
            if (!mode_reg) begin
                cnt_next = cnt_reg + ONE_W;
            end else if (dir_up_reg) begin
                if (cnt_reg == MAX) begin
                    if (MAX == ONE_W) begin
                        cnt_next = '0;
                    end else begin
                        cnt_next    = MAX - ONE_W;
                        dir_up_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + ONE_W;
                end
            end else begin
                if (cnt_reg == ONE_W) begin
                    cnt_next    = '0;
                    dir_up_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - ONE_W;
                end
            end
        end
    end

    // Counter, mode, request history and period pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg          <= '0;
            dir_up_reg       <= 1'b1;
            mode_reg         <= 1'b0;
            inc_prev_reg     <= '0;
            dec_prev_reg     <= '0;
            period_start_reg <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            dir_up_reg       <= dir_up_next;
            mode_reg         <= mode_next;
            inc_prev_reg     <= duty_inc;
            dec_prev_reg     <= duty_dec;
            period_start_reg <= en && boundary;
        end
    end

    assign period_start = period_start_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] shadow_reg, shadow_next;
            logic [WIDTH-1:0] active_reg, active_next;
            logic [WIDTH-1:0] duty_cmp;
            logic [WIDTH:0]   inc_sum;
            logic             load_hit;
            logic             pwm_reg;

            // Out-of-range ch_sel values never equal any channel index.
            assign load_hit = load && (ch_sel == SEL_W'(gi));
            assign inc_sum  = {1'b0, shadow_reg} + STEP_EXT;

            // Shadow duty: load wins, opposing edges cancel, steps saturate.
            always_comb begin
                shadow_next = shadow_reg;
                if (load_hit) begin
                    shadow_next = duty_in;
                end else if (inc_edge[gi] && dec_edge[gi]) begin
                    shadow_next = shadow_reg;
                end else if (inc_edge[gi]) begin
                    shadow_next = (inc_sum > MAX_EXT) ? MAX : inc_sum[WIDTH-1:0];
                end else if (dec_edge[gi]) begin
                    shadow_next = ({1'b0, shadow_reg} >= STEP_EXT) ? (shadow_reg - STEP_W) : '0;
                end
            end

            // Active duty follows the shadow at boundaries, or continuously
            // while stopped. The boundary cycle already compares against the
            // incoming value so the whole new period uses the new duty.
            always_comb begin
                active_next = active_reg;
                if (!en || boundary) begin
                    active_next = shadow_reg;
                end
                duty_cmp = boundary ? shadow_reg : active_reg;
            end

            // Per-channel duty registers and registered output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= INIT_W;
                    active_reg <= INIT_W;
                    pwm_reg    <= 1'b0;
                end else begin
                    shadow_reg <= shadow_next;
                    active_reg <= active_next;
                    pwm_reg    <= en && (cnt_reg < duty_cmp);
                end
            end

            assign PWM_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch (WIDTH=3, CHANNELS=2). A period-level model predicts
// every output cycle; per-period high counts measured on the outputs are also
// pinned against hand-computed numbers.
module tb_pwm_multi_ch;

    localparam int W    = 3;
    localparam int CH   = 2;
    localparam int MAXV = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          center;
    logic [CH-1:0] duty_inc;
    logic [CH-1:0] duty_dec;
    logic          load;
    logic [0:0]    ch_sel;
    logic [W-1:0]  duty_in;
    logic [CH-1:0] PWM_out;
    logic          period_start;

    int vectors     = 0;
    int miscompares = 0;

    pwm_multi_ch #(.WIDTH(W), .CHANNELS(CH), .STEP(1), .DUTY_INIT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .center(center),
        .duty_inc(duty_inc), .duty_dec(duty_dec), .load(load),
        .ch_sel(ch_sel), .duty_in(duty_in),
        .PWM_out(PWM_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Model state: position within the current period, not a counter replica
    int   m_phase;
    bit   m_center;
    int   m_shadow [CH];
    int   m_duty   [CH];
    logic [CH-1:0] m_prev_inc, m_prev_dec;
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    // Measurement of the DUT output per period
    int acc_high [CH];
    int last_high[CH];
    int acc_len, last_len;
    int ps_count = 0;

    function automatic int period_len(bit c);
        return c ? 2 * MAXV : MAXV + 1;
    endfunction

    // Counter value seen at a given phase: triangle in center mode
    function automatic int cnt_at(int phase, bit c);
        if (!c) return phase;
        return (phase <= MAXV) ? phase : 2 * MAXV - phase;
    endfunction

    // Model update on each edge, then compare the DUT 1 time unit later
    always begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_center = 0;
            for (int i = 0; i < CH; i++) begin
                m_shadow[i] = 4;
                m_duty[i] = 4;
            end
            m_prev_inc = '0;
            m_prev_dec = '0;
            exp_pwm = '0;
            exp_ps = 1'b0;
        end else begin
            if (en) begin
                if (m_phase == 0) begin
                    for (int i = 0; i < CH; i++) m_duty[i] = m_shadow[i];
                    m_center = center;
                end
                exp_ps = (m_phase == 0);
                for (int i = 0; i < CH; i++)
                    exp_pwm[i] = (cnt_at(m_phase, m_center) < m_duty[i]);
                m_phase = (m_phase + 1) % period_len(m_center);
            end else begin
                m_phase = 0;
                for (int i = 0; i < CH; i++) m_duty[i] = m_shadow[i];
                m_center = center;
                exp_pwm = '0;
                exp_ps = 1'b0;
            end
            for (int i = 0; i < CH; i++) begin
                bit ie, de;
                ie = duty_inc[i] && !m_prev_inc[i];
                de = duty_dec[i] && !m_prev_dec[i];
                if (load && (int'(ch_sel) == i)) m_shadow[i] = int'(duty_in);
                else if (ie && de) m_shadow[i] = m_shadow[i];
                else if (ie) m_shadow[i] = (m_shadow[i] + 1 > MAXV) ? MAXV : m_shadow[i] + 1;
                else if (de) m_shadow[i] = (m_shadow[i] - 1 < 0) ? 0 : m_shadow[i] - 1;
            end
            m_prev_inc = duty_inc;
            m_prev_dec = duty_dec;
        end
        #1;
        vectors++;
        if (PWM_out !== exp_pwm || period_start !== exp_ps) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t: PWM_out=%b period_start=%b, expected PWM_out=%b period_start=%b",
                     $time, PWM_out, period_start, exp_pwm, exp_ps);
        end
        if (period_start === 1'b1) begin
            for (int i = 0; i < CH; i++) begin
                last_high[i] = acc_high[i];
                acc_high[i] = int'(PWM_out[i]);
            end
            last_len = acc_len;
            acc_len = 1;
            ps_count++;
        end else begin
            for (int i = 0; i < CH; i++) acc_high[i] += int'(PWM_out[i] === 1'b1);
            acc_len++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_periods(input int n);
        int target;
        int budget;
        target = ps_count + n;
        budget = 0;
        while (ps_count < target && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (ps_count < target) begin
            vectors++;
            miscompares++;
            $display("FAIL period_timeout: saw %0d period starts, expected %0d", ps_count, target);
        end
    endtask

    task automatic check_period(input string name, input int h0, input int h1, input int len);
        check_lit({name, "_ch0_high"}, last_high[0], h0);
        check_lit({name, "_ch1_high"}, last_high[1], h1);
        check_lit({name, "_len"}, last_len, len);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) acc_high[i] = 0;
        acc_len = 0;
        last_len = 0;
        rst = 1'b1; en = 1'b0; center = 1'b0;
        duty_inc = '0; duty_dec = '0; load = 1'b0; ch_sel = '0; duty_in = '0;
        repeat (5) @(negedge clk);
        check_lit("reset_pwm", int'(PWM_out), 0);
        check_lit("reset_ps", int'(period_start), 0);

        // Edge-aligned baseline
        rst = 1'b0; en = 1'b1;
        wait_periods(3);
        check_period("baseline", 4, 4, 8);

        // Held increment request gives one step, effective next period
        @(negedge clk); @(negedge clk);
        duty_inc[0] = 1'b1;
        repeat (3) @(negedge clk);
        duty_inc[0] = 1'b0;
        wait_periods(1);
        check_period("inc_same_period", 4, 4, 8);
        wait_periods(1);
        check_period("inc_next_period", 5, 4, 8);

        // Saturation at MAX
        repeat (4) begin
            duty_inc[0] = 1'b1; @(negedge clk);
            duty_inc[0] = 1'b0; @(negedge clk);
        end
        wait_periods(2);
        check_period("sat_max", 7, 4, 8);

        // Saturation at 0
        ch_sel = 1'b1; duty_in = 3'd0; load = 1'b1; @(negedge clk);
        load = 1'b0; @(negedge clk);
        duty_dec[1] = 1'b1; @(negedge clk);
        duty_dec[1] = 1'b0;
        wait_periods(2);
        check_period("sat_zero", 7, 0, 8);

        // Load beats a same-cycle inc edge; opposing edges cancel
        ch_sel = 1'b1; duty_in = 3'd2; load = 1'b1; duty_inc[1] = 1'b1; @(negedge clk);
        load = 1'b0; @(negedge clk);
        duty_inc[1] = 1'b0;
        ch_sel = 1'b0; duty_in = 3'd5; load = 1'b1; @(negedge clk);
        load = 1'b0; duty_inc[0] = 1'b1; duty_dec[0] = 1'b1; @(negedge clk);
        duty_inc[0] = 1'b0; duty_dec[0] = 1'b0;
        wait_periods(2);
        check_period("priority", 5, 2, 8);

        // Center-aligned mode
        center = 1'b1; ch_sel = 1'b0; duty_in = 3'd3; load = 1'b1; @(negedge clk);
        load = 1'b0;
        wait_periods(3);
        check_period("center", 5, 3, 14);

        // Enable drop mid-period, then restart with a new duty in edge mode
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check_lit("en_off_pwm", int'(PWM_out), 0);
        check_lit("en_off_ps", int'(period_start), 0);
        center = 1'b0; ch_sel = 1'b0; duty_in = 3'd6; load = 1'b1; @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #2;
        check_lit("restart_ps", int'(period_start), 1);
        wait_periods(1);
        check_period("restart", 6, 2, 8);

        // Reset mid-period restores initial duties
        repeat (3) @(negedge clk);
        rst = 1'b1; @(negedge clk);
        check_lit("midreset_pwm", int'(PWM_out), 0);
        rst = 1'b0;
        wait_periods(2);
        check_period("after_reset", 4, 4, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator, the successor to the single-channel 3-bit PWM. It has CHANNELS independent outputs sharing one WIDTH-bit period counter. Each channel's duty is set by edge-detected increment/decrement requests with saturation, or by a direct load. Duty updates are double-buffered so that a new value only takes effect at a period boundary, and the block supports edge-aligned and center-aligned modes.

## Interface
- WIDTH, 8: counter and duty width; MAX = 2^WIDTH-1
- CHANNELS, 4: number of PWM outputs
- STEP, 1: duty change per inc/dec request
- DUTY_INIT, 2^(WIDTH-1): per-channel duty after reset

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- center  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary
- duty_inc  in  CHANNELS  per-channel increment request, level input, acted on at rising edge
- duty_dec  in  CHANNELS  per-channel decrement request, same rules
- load  in  1  write duty_in to shadow duty of channel ch_sel
- ch_sel  in  clog2(CHANNELS)  load target; out-of-range ignored
- duty_in  in  WIDTH  load value
- PWM_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse at each period boundary

## Operation
- Counter cnt (WIDTH bits) and direction bit.
  - Edge mode: cnt counts 0..MAX and wraps to 0. Period is 2^WIDTH cycles.
  - Center mode: cnt counts up 0..MAX, then down MAX-1..1, then returns to 0. Period is 2*MAX cycles.
- Period boundary: a cycle where cnt==0 with direction up.
- Per channel there are two registers: shadow duty and active duty.
- Request detection:
  - Rising edge of duty_inc[i] or duty_dec[i] is detected against the registered previous value.
  - A held request gives exactly one step.
- Shadow update priority per channel, per cycle:
  - load hitting channel i: shadow = duty_in. The same-cycle inc/dec edge on that channel is dropped.
  - inc edge and dec edge together: no change.
  - inc edge: shadow = min(shadow+STEP, MAX), computed at WIDTH+1 bits and saturated.
  - dec edge: shadow = max(shadow-STEP, 0), with no underflow.
- Active update:
  - At each period boundary with en=1, active = shadow (all channels simultaneously) and mode = center.
  - While en=0, active tracks shadow every cycle and mode tracks center.
- Output: PWM_out[i] is registered as en && (cnt < active[i]).
  - Edge mode: high for `duty` cycles per period. duty=0 gives constant low; duty=MAX gives high MAX of 2^WIDTH cycles.
  - Center mode: high for 2*duty-1 cycles, contiguous around cnt=0, when duty≥1. duty=0 gives constant low.
- en=0 holds cnt=0 with direction up. PWM_out and period_start are 0.
  - Inc/dec/load remain functional while en=0.
- en 0→1: counting starts at cnt=0 (a boundary) on the next cycle.
- Mode change via center only at a boundary; no partial periods.

## Timing
- Reset values:
  - cnt=0, direction up, mode=edge.
  - shadow = active = DUTY_INIT.
  - Edge-detect registers = 0.
  - PWM_out=0, period_start=0.
- rst has priority over en, load and requests. Reset mid-period truncates the period immediately; outputs are 0 on the cycle after rst is sampled high.
- Output latency: one cycle. PWM_out at cycle t+1 reflects cnt and active at cycle t.
- period_start is registered and aligned with the PWM_out cycle derived from cnt==0.
- Inc/dec edge to shadow: the shadow updates at the end of the cycle in which the rising edge is sampled.
- Shadow to effect on PWM_out: from the first output cycle of the next period, i.e. worst case one full period plus one cycle.
- A request in the same cycle as a boundary reaches shadow too late for that transfer. It takes effect in the following period.

## Test plan
- Reset and edge baseline (WIDTH=3, CHANNELS=2, STEP=1, DUTY_INIT=4): rst high 5 cycles, then en=1 and center=0.
  - Expected: PWM_out=00 during reset.
  - Expected: each channel high 4 of every 8 cycles, with period_start every 8 cycles.
- Single step on a held request: duty_inc[0] held 3 cycles mid-period.
  - Expected: ch0 shadow 4→5 once.
  - Expected: ch0 high 5 of 8 starting the next period; the current period remains 4 of 8; ch1 unchanged at 4 of 8.
- Saturation:
  - Four separate inc pulses on ch0 from 5: duty goes to 7 (high 7 of 8), never wraps to 0.
  - Load ch1=0, then a dec pulse: duty stays 0 and ch1 stays constant low.
- Priority cases:
  - load ch_sel=1, duty_in=2 in the same cycle as an inc edge on ch1: shadow = 2.
  - Simultaneous inc and dec edges on ch0: shadow unchanged.
- Center mode: set center=1, load ch0=3.
  - Expected: after the boundary, period is 14 cycles.
  - Expected: ch0 is high 5 contiguous cycles (cnt 2,1,0,1,2 wrapping across the boundary); ch1 at duty 2 is high 3 cycles.
- Enable drop mid-period: en=0 at cnt=5.
  - Expected: PWM_out=0 from the next cycle and cnt holds 0.
  - Expected: re-assert en with a changed shadow; the new duty applies from the first period after restart, with period_start on restart.
